tm1638_led_driver: RTL and testbench

- Downstream of LED_Pattern.
- Takes its parallel `led[7:0]` and drives the 8 discrete LEDs on the TM1638 board over the 3-wire serial link (STB/CLK/DIO).
- Write-only: no key scan, DIO driven as output only.
- Refreshes the board whenever the LED vector changes, and once unconditionally after reset.

---
 rtl/tm1638_pkg.sv | 29 ++
 rtl/tm1638_byte_tx.sv | 89 ++++++++
 rtl/tm1638_led_driver.sv | 146 ++++++++++++++
 tb/tb_tm1638_led_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state type and frame byte lookup for the TM1638 LED driver.
package tm1638_pkg;

   localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
   localparam logic [7:0] CMD_ADDR_BASE  = 8'hC0;
   localparam logic [7:0] CMD_DISP_ON    = 8'h88;
   localparam logic [3:0] LAST_TXN       = 4'd9;

   typedef enum logic [2:0] {IDLE, STB_SETUP, SHIFT, STB_HOLD, GAP} state_e;

   // Byte sent in transaction txn; second selects the data byte of an LED pair.
   function automatic logic [7:0] frame_byte(input logic [3:0] txn, input logic second,
                                             input logic [7:0] snap, input logic [2:0] bright);
      logic [7:0] b;
      logic [3:0] idx;
      idx = txn - 4'd1;
      b   = CMD_DATA_FIXED;
      if (txn == LAST_TXN)
         b = CMD_DISP_ON | {5'b0, bright};
      else if (txn != 4'd0) begin
         if (second)
            b = {7'b0, snap[idx[2:0]]};
         else
            b = CMD_ADDR_BASE + {3'b0, txn, 1'b0} - 8'd1;
      end
      return b;
   endfunction

endpackage

// File: rtl/tm1638_byte_tx.sv
// Shifts one byte LSB first: CLK low D cycles (DIO updated on the fall), high D cycles, per bit.
module tm1638_byte_tx #(
   parameter int CLK_DIV = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   input  logic       release_i,
   output logic       clk_o,
   output logic       dio_o,
   output logic       ready_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   logic          active_q, active_d;
   logic          hi_q, hi_d;
   logic [CW-1:0] div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          clk_q, clk_d;
   logic          dio_q, dio_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         hi_q     <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
         clk_q    <= 1'b1;
         dio_q    <= 1'b1;
      end else begin
         active_q <= active_d;
         hi_q     <= hi_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         clk_q    <= clk_d;
         dio_q    <= dio_d;
      end
   end

   always_comb begin
      active_d = active_q;
      hi_d     = hi_q;
      div_d    = div_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      clk_d    = clk_q;
      dio_d    = dio_q;
      if (start_i) begin
         active_d = 1'b1;
         hi_d     = 1'b0;
         div_d    = '0;
         bit_d    = '0;
         sh_d     = byte_i;
         clk_d    = 1'b0;
         dio_d    = byte_i[0];
      end else if (active_q) begin
         if (div_q != DIV_LAST)
            div_d = div_q + 1'b1;
         else begin
            div_d = '0;
            if (!hi_q) begin
               hi_d  = 1'b1;
               clk_d = 1'b1;
            end else if (bit_q == 3'd7)
               active_d = 1'b0;
            else begin
               hi_d  = 1'b0;
               clk_d = 1'b0;
               bit_d = bit_q + 3'd1;
               sh_d  = {1'b0, sh_q[7:1]};
               dio_d = sh_q[1];
            end
         end
      // last bit is held while STB is low so DIO never moves under a high CLK
      end else if (release_i)
         dio_d = 1'b1;
   end

   assign ready_o = active_q & hi_q & (bit_q == 3'd7) & (div_q == DIV_LAST);
   assign clk_o   = clk_q;
   assign dio_o   = dio_q;

endmodule

// File: rtl/tm1638_led_driver.sv
// Sends the 8 LED states to a TM1638 board (write-only) on change and once after reset.
module tm1638_led_driver #(
   parameter int         CLK_DIV    = 25,
   parameter logic [2:0] BRIGHTNESS = 3'd2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] led,
   output logic       tm_stb,
   output logic       tm_clk,
   output logic       tm_dio,
   output logic       busy,
   output logic       frame_done
);

   import tm1638_pkg::*;

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    txn_q, txn_d;
   logic          byte_q, byte_d;
   logic [7:0]    snap_q, snap_d;
   logic [7:0]    last_q, last_d;
   logic          force_q, force_d;
   logic          stb_q, stb_d;
   logic          busy_q, done_q, done_d;
   logic          tx_start, tx_ready, half_end, two_byte;
   logic [7:0]    tx_byte;

   assign half_end = (cnt_q == DIV_LAST);
   assign two_byte = (txn_q != 4'd0) && (txn_q != LAST_TXN);
   assign tx_byte  = frame_byte(txn_q, state_q == SHIFT, snap_q, BRIGHTNESS);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         txn_q   <= '0;
         byte_q  <= 1'b0;
         snap_q  <= '0;
         last_q  <= '0;
         force_q <= 1'b1;
         stb_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         txn_q   <= txn_d;
         byte_q  <= byte_d;
         snap_q  <= snap_d;
         last_q  <= last_d;
         force_q <= force_d;
         stb_q   <= stb_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      txn_d    = txn_q;
      byte_d   = byte_q;
      snap_d   = snap_q;
      last_d   = last_q;
      force_d  = force_q;
      done_d   = 1'b0;
      tx_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (force_q || (led != last_q)) begin
               snap_d  = led;
               last_d  = led;
               force_d = 1'b0;
               txn_d   = '0;
               byte_d  = 1'b0;
               cnt_d   = '0;
               state_d = STB_SETUP;
            end
         end
         STB_SETUP: begin
            if (half_end) begin
               cnt_d    = '0;
               tx_start = 1'b1;
               state_d  = SHIFT;
            end else
               cnt_d = cnt_q + 1'b1;
         end
         SHIFT: begin
            // the second byte of a pair starts back-to-back with the first
            if (tx_ready) begin
               if (two_byte && !byte_q) begin
                  byte_d   = 1'b1;
                  tx_start = 1'b1;
               end else begin
                  cnt_d   = '0;
                  state_d = STB_HOLD;
               end
            end
         end
         STB_HOLD: begin
            if (half_end) begin
               cnt_d   = '0;
               done_d  = (txn_q == LAST_TXN);
               state_d = GAP;
            end else
               cnt_d = cnt_q + 1'b1;
         end
         GAP: begin
            if (half_end) begin
               cnt_d = '0;
               if (txn_q == LAST_TXN)
                  state_d = IDLE;
               else begin
                  txn_d   = txn_q + 4'd1;
                  byte_d  = 1'b0;
                  state_d = STB_SETUP;
               end
            end else
               cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      stb_d = !((state_d == STB_SETUP) || (state_d == SHIFT) || (state_d == STB_HOLD));
   end

   tm1638_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk       (clk),
      .reset     (reset),
      .start_i   (tx_start),
      .byte_i    (tx_byte),
      .release_i (stb_d),
      .clk_o     (tm_clk),
      .dio_o     (tm_dio),
      .ready_o   (tx_ready)
   );

   assign tm_stb     = stb_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_tm1638_led_driver.sv
// Directed bench: decodes the serial link, checks frame contents, timing and protocol rules.
module tb_tm1638_led_driver;

   logic       clk = 1'b0;
   logic       rst_a = 1'b1, rst_b = 1'b1;
   logic [7:0] led_a = 8'h00, led_b = 8'h00;
   logic       stb_a, clk_a, dio_a, busy_a, done_a;
   logic       stb_b, clk_b, dio_b, busy_b, done_b;

   tm1638_led_driver #(.CLK_DIV(2), .BRIGHTNESS(3'd2)) dut_a (
      .clk(clk), .reset(rst_a), .led(led_a), .tm_stb(stb_a), .tm_clk(clk_a),
      .tm_dio(dio_a), .busy(busy_a), .frame_done(done_a));

   tm1638_led_driver #(.CLK_DIV(1), .BRIGHTNESS(3'd7)) dut_b (
      .clk(clk), .reset(rst_b), .led(led_b), .tm_stb(stb_b), .tm_clk(clk_b),
      .tm_dio(dio_b), .busy(busy_b), .frame_done(done_b));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   // link decoder and protocol watcher for dut_a
   logic       p_stb = 1'b1, p_clk = 1'b1, p_dio = 1'b1;
   logic [7:0] sh = 8'h00;
   logic [7:0] bq[$];
   int         bits = 0, low_cnt = 0, hi_run = 100;
   int         fall_cnt = 0, done_cnt = 0, done_cyc = 0, rise_cyc = 0, proto_err = 0;
   bit         clk_fallen = 1'b0;

   always @(negedge clk) begin
      if (!stb_a) begin
         if (p_stb) begin
            if (hi_run < 2) proto_err++;
            fall_cnt++;
            low_cnt    = 1;
            clk_fallen = 1'b0;
            bits       = 0;
         end else
            low_cnt++;
         hi_run = 0;
         if (p_clk && !clk_a && !clk_fallen) begin
            clk_fallen = 1'b1;
            if (low_cnt < 3) proto_err++;
         end
         if (clk_a && (dio_a !== p_dio)) proto_err++;
         if (!p_clk && clk_a) begin
            sh = {dio_a, sh[7:1]};
            bits++;
            if (bits == 8) begin
               bq.push_back(sh);
               bits = 0;
            end
         end
      end else begin
         if (!p_stb) begin
            rise_cyc = cyc;
            bits     = 0;
         end
         hi_run++;
      end
      if (done_a) begin
         done_cnt++;
         done_cyc = cyc;
      end
      p_stb = stb_a;
      p_clk = clk_a;
      p_dio = dio_a;
   end

   // byte decoder for dut_b
   logic       q_clk = 1'b1;
   logic [7:0] sh2 = 8'h00;
   logic [7:0] bq2[$];
   int         bits2 = 0;

   always @(negedge clk) begin
      if (stb_b)
         bits2 = 0;
      else if (!q_clk && clk_b) begin
         sh2 = {dio_b, sh2[7:1]};
         bits2++;
         if (bits2 == 8) begin
            bq2.push_back(sh2);
            bits2 = 0;
         end
      end
      q_clk = clk_b;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_frame(input string tag, input int base, input logic [7:0] l,
                            input logic [2:0] br);
      logic [7:0] e[18];
      e[0] = 8'h44;
      for (int i = 0; i < 8; i++) begin
         e[1 + 2*i] = 8'hC1 + 8'(2*i);
         e[2 + 2*i] = {7'b0, l[i]};
      end
      e[17] = 8'h88 | {5'b0, br};
      check({tag, "_nbytes"}, bq.size() - base, 18);
      for (int i = 0; i < 18; i++) begin
         if (base + i < bq.size())
            check($sformatf("%s_byte%0d", tag, i), {24'h0, bq[base + i]}, {24'h0, e[i]});
         else
            check($sformatf("%s_byte%0d", tag, i), 32'h1FF, {24'h0, e[i]});
      end
   endtask

   task automatic wait_fall(output int c);
      int n = 0;
      while (stb_a !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("stb_fall_wait", n < 20, 1);
      c = cyc;
   endtask

   task automatic wait_idle(output int c);
      int n = 0;
      while (busy_a !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("busy_fall_wait", n < 2000, 1);
      c = cyc;
   endtask

   initial begin
      int t0, t1, base, dbase, fc, n;

      // reset values
      repeat (5) @(negedge clk);
      check("rst_stb", stb_a, 1);
      check("rst_clk", clk_a, 1);
      check("rst_dio", dio_a, 1);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);

      // forced refresh after reset, led=00
      base  = bq.size();
      dbase = done_cnt;
      rst_a = 1'b0;
      @(negedge clk);
      check("start_stb", stb_a, 0);
      check("start_busy", busy_a, 1);
      t0 = cyc;
      wait_idle(t1);
      check("f00_len", t1 - t0, 636);
      cmp_frame("f00", base, 8'h00, 3'd2);
      check("f00_done_cnt", done_cnt - dbase, 1);
      check("f00_done_at_stb_rise", done_cyc, rise_cyc);

      fc = fall_cnt;
      repeat (30) @(negedge clk);
      check("idle_quiet", fall_cnt - fc, 0);

      // led=81 then held
      base  = bq.size();
      led_a = 8'h81;
      wait_fall(t0);
      wait_idle(t1);
      check("f81_len", t1 - t0, 636);
      cmp_frame("f81", base, 8'h81, 3'd2);
      fc = fall_cnt;
      repeat (60) @(negedge clk);
      check("hold_quiet", fall_cnt - fc, 0);
      check("hold_stb", stb_a, 1);
      check("hold_busy", busy_a, 0);

      // led 01 -> 02 at cycle 100 of the frame
      base  = bq.size();
      led_a = 8'h01;
      wait_fall(t0);
      while (cyc < t0 + 100) @(negedge clk);
      led_a = 8'h02;
      wait_idle(t1);
      cmp_frame("f01", base, 8'h01, 3'd2);
      base = bq.size();
      @(negedge clk);
      check("refire_stb", stb_a, 0);
      check("refire_busy", busy_a, 1);
      t0 = cyc;
      wait_idle(t1);
      check("f02_len", t1 - t0, 636);
      cmp_frame("f02", base, 8'h02, 3'd2);

      // reset at cycle 300 of a frame
      led_a = 8'h55;
      wait_fall(t0);
      while (cyc < t0 + 300) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      check("midrst_stb", stb_a, 1);
      check("midrst_clk", clk_a, 1);
      check("midrst_dio", dio_a, 1);
      check("midrst_busy", busy_a, 0);
      repeat (3) @(negedge clk);
      base  = bq.size();
      dbase = done_cnt;
      rst_a = 1'b0;
      wait_fall(t0);
      wait_idle(t1);
      check("frst_len", t1 - t0, 636);
      cmp_frame("frst", base, 8'h55, 3'd2);
      check("frst_done_cnt", done_cnt - dbase, 1);
      check("frst_done_at_stb_rise", done_cyc, rise_cyc);
      check("protocol_violations", proto_err, 0);

      // CLK_DIV=1, BRIGHTNESS=7
      rst_b = 1'b0;
      n = 0;
      while (stb_b !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("b_stb_fall_wait", n < 20, 1);
      t0 = cyc;
      n  = 0;
      while (busy_b !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("b_busy_fall_wait", n < 1000, 1);
      t1 = cyc;
      check("b_len", t1 - t0, 318);
      check("b_nbytes", bq2.size(), 18);
      if (bq2.size() > 0) check("b_first", {24'h0, bq2[0]}, 32'h44);
      else                check("b_first", 32'h1FF, 32'h44);
      if (bq2.size() == 18) check("b_last", {24'h0, bq2[17]}, 32'h8F);
      else                  check("b_last", 32'h1FF, 32'h8F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
